// File: rtl/io_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_bridge_pkg                                                        |
// | Shared constants for io_bridge: MMIO addresses, 7-seg table, resets. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package io_bridge_pkg;

  localparam logic [31:0] c_mmio_base  = 32'hFFFF_F000;
  localparam logic [31:0] c_addr_disp  = 32'hFFFF_F000;
  localparam logic [31:0] c_addr_tcnt  = 32'hFFFF_F020;
  localparam logic [31:0] c_addr_tpre  = 32'hFFFF_F024;
  localparam logic [31:0] c_addr_led   = 32'hFFFF_F060;
  localparam logic [31:0] c_addr_sw    = 32'hFFFF_F070;
  localparam logic [31:0] c_addr_btn   = 32'hFFFF_F078;

  localparam logic [7:0] c_dig_en_rst  = 8'hFE;
  localparam logic [7:0] c_dig_seg_rst = 8'hC0;

  // Active-low {dp,g,f,e,d,c,b,a}, entry n at bits [8n+7:8n], dp always off.
  localparam logic [127:0] c_seg_table = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [2:0] {
    SEL_DRAM = 3'd0,
    SEL_DISP = 3'd1,
    SEL_LED  = 3'd2,
    SEL_SW   = 3'd3,
    SEL_BTN  = 3'd4,
    SEL_TCNT = 3'd5,
    SEL_TPRE = 3'd6,
    SEL_NONE = 3'd7
  } sel_e;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] i_nib);
    return c_seg_table[{i_nib, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_bridge_seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan                                                            |
// | Time-multiplexed scan of an 8-digit active-low 7-segment display.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_scan
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_disp,
  output logic [7:0]  o_dig_en,
  output logic [7:0]  o_dig_seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] r_scan_cnt;
  logic [2:0]    r_dsel;
  logic          w_wrap;
  logic [3:0]    w_nib;

  assign w_wrap = (r_scan_cnt == CW'(SCAN_DIV - 1));
  // Nibble is taken from the live register so display writes show up mid-scan.
  assign w_nib  = i_disp[{r_dsel, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_dsel     <= '0;
      o_dig_en   <= c_dig_en_rst;
      o_dig_seg  <= c_dig_seg_rst;
    end else begin
      r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
      if (w_wrap) r_dsel <= r_dsel + 1'b1;
      o_dig_en  <= ~(8'h01 << r_dsel);
      o_dig_seg <= hex_to_seg(w_nib);
    end
  end

endmodule
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_bridge                                                            |
// | CPU data-port bridge: DRAM / MMIO decode, LEDs, switches, buttons,   |
// | 7-seg display; optional timer enabled by macro BRIDGE_TIMER_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int SCAN_DIV        = 20000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  output logic [31:0] cpu_rdata,
  output logic [13:0] dram_addr,
  output logic [31:0] dram_wdata,
  output logic        dram_we,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic        w_is_mmio;
  logic [31:0] w_waddr;
  sel_e        w_sel;

  logic [31:0] r_disp;
  logic [23:0] r_led;
  logic [23:0] r_sw_meta, r_sw_sync;
  logic [4:0]  r_btn_meta, r_btn_sync;
  logic [4:0]  w_btn_db;

  assign w_is_mmio = (cpu_addr >= c_mmio_base);
  assign w_waddr   = {cpu_addr[31:2], 2'b00};

  always_comb begin
    w_sel = SEL_NONE;
    if (!w_is_mmio) begin
      w_sel = SEL_DRAM;
    end else begin
      case (w_waddr)
        c_addr_disp: w_sel = SEL_DISP;
        c_addr_led:  w_sel = SEL_LED;
        c_addr_sw:   w_sel = SEL_SW;
        c_addr_btn:  w_sel = SEL_BTN;
        c_addr_tcnt: w_sel = SEL_TCNT;
        c_addr_tpre: w_sel = SEL_TPRE;
        default:     w_sel = SEL_NONE;
      endcase
    end
  end

  assign dram_addr  = cpu_addr[15:2];
  assign dram_wdata = cpu_wdata;
  assign dram_we    = cpu_we && (w_sel == SEL_DRAM);

`ifdef BRIDGE_TIMER_EN
  logic [31:0] r_tcnt, r_tpre, r_pcnt;
  logic        w_tick;

  assign w_tick = (r_pcnt == r_tpre);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_tcnt <= '0;
      r_tpre <= '0;
      r_pcnt <= '0;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      // A CPU write to the count beats a same-cycle increment.
      if (cpu_we && (w_sel == SEL_TCNT)) r_tcnt <= cpu_wdata;
      else if (w_tick)                   r_tcnt <= r_tcnt + 1'b1;
      if (cpu_we && (w_sel == SEL_TPRE)) r_tpre <= cpu_wdata;
    end
  end
`endif

  always_comb begin
    cpu_rdata = '0;
    case (w_sel)
      SEL_DRAM: cpu_rdata = dram_rdata;
      SEL_DISP: cpu_rdata = r_disp;
      SEL_LED:  cpu_rdata = {8'b0, r_led};
      SEL_SW:   cpu_rdata = {8'b0, r_sw_sync};
      SEL_BTN:  cpu_rdata = {27'b0, w_btn_db};
`ifdef BRIDGE_TIMER_EN
      SEL_TCNT: cpu_rdata = r_tcnt;
      SEL_TPRE: cpu_rdata = r_tpre;
`endif
      default:  cpu_rdata = '0;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_disp     <= '0;
      r_led      <= '0;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      if (cpu_we && (w_sel == SEL_DISP)) r_disp <= cpu_wdata;
      if (cpu_we && (w_sel == SEL_LED))  r_led  <= cpu_wdata[23:0];
      r_sw_meta  <= sw;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= btn;
      r_btn_sync <= r_btn_meta;
    end
  end

  assign led = r_led;

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    logic [DBW-1:0] r_cnt;
    logic           r_db;

    always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_btn_sync[gi] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_btn_sync[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_btn_db[gi] = r_db;
  end

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .i_disp    (r_disp),
    .o_dig_en  (dig_en),
    .o_dig_seg (dig_seg)
  );

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_io_bridge                                                         |
// | Self-checking bench for io_bridge against a behavioural model.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_io_bridge;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam logic [31:0] MMIO = 32'hFFFF_F000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_rdata;
  logic [13:0] dram_addr;
  logic [31:0] dram_wdata;
  logic        dram_we;
  logic [31:0] dram_rdata;
  logic [23:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  io_bridge #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
    .dram_rdata(dram_rdata), .sw(sw), .btn(btn), .led(led),
    .dig_en(dig_en), .dig_seg(dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // DRAM stub driven by the DUT's DRAM port.
  logic [31:0] mem [0:16383];
  assign dram_rdata = mem[dram_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] exp_mem [int];
  int          k;
  logic [31:0] m_disp;
  logic [23:0] m_led, m_sw, sw_q1;
  logic [4:0]  b_q1, b_q2, m_db;
  int          run [5];
  logic [31:0] m_tcnt, m_tpre, m_pcnt;
  logic [7:0]  e_en, e_seg;
  logic [31:0] addrs [8];

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (a < MMIO) return exp_mem[int'(a[15:2])];
    case (w)
      32'hFFFF_F000: return m_disp;
      32'hFFFF_F060: return {8'b0, m_led};
      32'hFFFF_F070: return {8'b0, m_sw};
      32'hFFFF_F078: return {27'b0, m_db};
`ifdef BRIDGE_TIMER_EN
      32'hFFFF_F020: return m_tcnt;
      32'hFFFF_F024: return m_tpre;
`endif
      default:       return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("led", {8'b0, led}, {8'b0, m_led});
    chk("dig_en", {24'b0, dig_en}, {24'b0, e_en});
    chk("dig_seg", {24'b0, dig_seg}, {24'b0, e_seg});
    chk("dram_we", {31'b0, dram_we}, {31'b0, cpu_we && (cpu_addr < MMIO)});
    if (cpu_addr >= MMIO || exp_mem.exists(int'(cpu_addr[15:2])))
      chk("rdata", cpu_rdata, exp_rdata(cpu_addr));
  endtask

  task automatic tick();
    logic        we, rst, d_we;
    logic [31:0] a, wd, w, d_wd;
    logic [13:0] d_a;
    logic [23:0] sw_c;
    logic [4:0]  btn_c;
    logic        mmio, inc;
    int          idx;
    we = cpu_we; a = cpu_addr; wd = cpu_wdata; rst = cpu_rst;
    sw_c = sw; btn_c = btn; d_we = dram_we; d_a = dram_addr; d_wd = dram_wdata;
    @(posedge cpu_clk);
    #1;
    if (d_we) mem[d_a] = d_wd;
    w = {a[31:2], 2'b00};
    mmio = (a >= MMIO);
    if (we && !mmio) exp_mem[int'(a[15:2])] = wd;
    if (rst) begin
      k = 0; m_disp = '0; m_led = '0; m_sw = '0; sw_q1 = '0;
      b_q1 = '0; b_q2 = '0; m_db = '0;
      for (int i = 0; i < 5; i++) run[i] = 0;
      m_tcnt = '0; m_tpre = '0; m_pcnt = '0;
      e_en = 8'hFE; e_seg = 8'hC0;
    end else begin
      idx   = (k / SD) % 8;
      e_en  = ~(8'h01 << idx);
      e_seg = hex7(m_disp[4*idx +: 4]);
      k++;
      m_sw = sw_q1; sw_q1 = sw_c;
      for (int i = 0; i < 5; i++) begin
        if (b_q2[i] != m_db[i]) run[i]++; else run[i] = 0;
        if (run[i] == DB) begin m_db[i] = b_q2[i]; run[i] = 0; end
      end
      b_q2 = b_q1; b_q1 = btn_c;
      inc = (m_pcnt == m_tpre);
      m_pcnt = inc ? 32'h0 : m_pcnt + 1;
      if (we && w == 32'hFFFF_F020) m_tcnt = wd;
      else if (inc) m_tcnt = m_tcnt + 1;
      if (we && w == 32'hFFFF_F024) m_tpre = wd;
      if (we && w == 32'hFFFF_F000) m_disp = wd;
      if (we && w == 32'hFFFF_F060) m_led = wd[23:0];
    end
  endtask

  task automatic setin(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_we = we; cpu_addr = a; cpu_wdata = d;
    #1;
    check_all();
  endtask

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
    setin(we, a, d);
    tick();
  endtask

  initial begin
    logic [31:0] mm [7];
    mm = '{32'hFFFF_F000, 32'hFFFF_F060, 32'hFFFF_F070, 32'hFFFF_F078,
           32'hFFFF_F020, 32'hFFFF_F024, 32'hFFFF_F0FC};
    cpu_rst = 1'b1;
    tick(); tick();
    cpu_rst = 1'b0;

    // Reset state.
    setin(0, 32'hFFFF_F000, 0);
    chk("rst_dig_en", {24'b0, dig_en}, 32'hFE);
    chk("rst_dig_seg", {24'b0, dig_seg}, 32'hC0);
    chk("rst_led", {8'b0, led}, 32'h0);
    tick();
    cyc(0, 32'hFFFF_F078, 0);
    cyc(0, 32'hFFFF_F070, 0);

    // DRAM store / load.
    setin(1, 32'h0000_0100, 32'h1234_5678);
    chk("dram_we_st", {31'b0, dram_we}, 32'h1);
    chk("dram_addr", {18'b0, dram_addr}, 32'h40);
    chk("dram_wdata", dram_wdata, 32'h1234_5678);
    tick();
    setin(0, 32'h0000_0100, 0);
    chk("dram_load", cpu_rdata, 32'h1234_5678);
    tick();
    for (int i = 0; i < 8; i++) begin
      addrs[i] = 32'h200 + 32'(i) * 32'h44;
      cyc(1, addrs[i], $urandom);
    end

    // LED register and unmapped page.
    setin(1, 32'hFFFF_F060, 32'h00AB_CDEF);
    chk("led_dram_we", {31'b0, dram_we}, 32'h0);
    tick();
    setin(0, 32'hFFFF_F060, 0);
    chk("led_out", {8'b0, led}, 32'h00AB_CDEF);
    chk("led_read", cpu_rdata, 32'h00AB_CDEF);
    tick();
    setin(1, 32'hFFFF_F100, 32'hDEAD_BEEF);
    chk("unmap_we", {31'b0, dram_we}, 32'h0);
    tick();
    setin(0, 32'hFFFF_F100, 0);
    chk("unmap_rd", cpu_rdata, 32'h0);
    tick();

    // Display scan from reset with 0x000000F8.
    cpu_rst = 1'b1; tick(); cpu_rst = 1'b0;
    cyc(1, 32'hFFFF_F000, 32'h0000_00F8);
    for (int i = 0; i < 36; i++) begin
      setin(0, 32'hFFFF_F000, 0);
      if (k == 2) chk("scan_d0", {dig_en, dig_seg}, 32'hFE80);
      if (k == 5) chk("scan_d1", {dig_en, dig_seg}, 32'hFD8E);
      if (k == 33) chk("scan_wrap", {24'b0, dig_en}, 32'hFE);
      tick();
    end

    // Switch synchroniser.
    sw = 24'h5A5A5A;
    for (int i = 1; i <= 4; i++) begin
      setin(0, 32'hFFFF_F070, 0);
      if (i == 3) chk("sw_lat", cpu_rdata, 32'h005A_5A5A);
      tick();
    end

    // Button glitch then a held press.
    btn = 5'h01;
    for (int i = 0; i < 5; i++) cyc(0, 32'hFFFF_F078, 0);
    btn = 5'h00;
    for (int i = 0; i < 14; i++) cyc(0, 32'hFFFF_F078, 0);
    setin(0, 32'hFFFF_F078, 0);
    chk("btn_glitch", cpu_rdata, 32'h0);
    btn = 5'h01;
    for (int i = 1; i <= 13; i++) begin
      setin(0, 32'hFFFF_F078, 0);
      if (i == 10) chk("btn_early", cpu_rdata, 32'h0);
      if (i == 11) chk("btn_db", cpu_rdata, 32'h1);
      tick();
    end

`ifdef BRIDGE_TIMER_EN
    cpu_rst = 1'b1; tick(); cpu_rst = 1'b0;
    cyc(1, 32'hFFFF_F024, 32'd2);
    for (int i = 0; i < 10; i++) cyc(0, 32'hFFFF_F020, 0);
    cyc(1, 32'hFFFF_F020, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) cyc(0, 32'hFFFF_F020, 0);
    cyc(0, 32'hFFFF_F020, 0);
    cpu_rst = 1'b1; tick(); cpu_rst = 1'b0;
    setin(0, 32'hFFFF_F020, 0);
    chk("tmr_rst", cpu_rdata, 32'h0);
    tick();
`else
    cyc(1, 32'hFFFF_F020, 32'h55AA_55AA);
    setin(0, 32'hFFFF_F020, 0);
    chk("tmr_absent", cpu_rdata, 32'h0);
    tick();
`endif

    // Randomised mix of traffic with one mid-run reset.
    for (int i = 0; i < 300; i++) begin
      int op;
      if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 15) == 0) btn = 5'($urandom);
      cpu_rst = (i == 150);
      op = $urandom_range(0, 6);
      case (op)
        0: cyc(1, addrs[$urandom_range(0, 7)], $urandom);
        1: cyc(0, addrs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)), 0);
        2: cyc(1, 32'hFFFF_F060, $urandom);
        3: cyc(1, 32'hFFFF_F000, $urandom);
        4: cyc(1, 32'hFFFF_F024, 32'($urandom_range(0, 3)));
        5: cyc(1, 32'hFFFF_F020, $urandom);
        default: cyc(0, mm[$urandom_range(0, 6)], 0);
      endcase
      if (i == 150) chk("midrst_led", {8'b0, led}, 32'h0);
    end
    cpu_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
